// File: rtl/vga_pkg.sv
// vga_pkg: playfield geometry and game-state encodings shared by the pong blocks.
// Contents:
//   X_PAD_LEFT, X_PAD_RIGHT, PAD_WIDTH, BALL_SIZE - horizontal geometry in pixels
//   MENU_START, GAME_PLAY                         - 2-bit game state codes
package vga_pkg;

    localparam int unsigned X_PAD_LEFT  = 20;
    localparam int unsigned X_PAD_RIGHT = 610;
    localparam int unsigned PAD_WIDTH   = 10;
    localparam int unsigned BALL_SIZE   = 10;

    localparam logic [1:0] MENU_START = 2'd0;
    localparam logic [1:0] GAME_PLAY  = 2'd1;

endpackage

// File: rtl/goal_detector.sv
// goal_detector: purely combinational classification of the ball x position.
// Ports:
//   x_ball     in  11  ball left edge in pixels
//   goal_left  out 1   ball is past the left paddle line (player 2 scores)
//   goal_right out 1   ball right edge is past the right paddle (player 1 scores)
//   in_field   out 1   neither goal condition holds
module goal_detector
    import vga_pkg::*;
(
    input  logic [10:0] x_ball,
    output logic        goal_left,
    output logic        goal_right,
    output logic        in_field
);

    // 12-bit arithmetic so x_ball + BALL_SIZE cannot overflow.
    logic [11:0] x_ext;
    logic [11:0] right_edge;

    always_comb begin
        x_ext      = {1'b0, x_ball};
        right_edge = x_ext + 12'(BALL_SIZE);
        goal_left  = x_ext < 12'(X_PAD_LEFT);
        goal_right = right_edge > 12'(X_PAD_RIGHT + PAD_WIDTH);
        in_field   = !goal_left && !goal_right;
    end

endmodule

// File: rtl/match_score_controller.sv
// match_score_controller: pong point/match tracker.
// Scores one point per goal excursion on timing_tick, detects the match winner (optionally
// win-by-two with deuce collapse) and freezes until rst or MENU_START.
// Ports:
//   clk            in  1        system clock
//   rst            in  1        synchronous active-high reset
//   timing_tick    in  1        frame enable; detection only when high
//   x_ball         in  11       ball left edge
//   state          in  2        game state; MENU_START restarts the match
//   player1_score  out SCORE_W  left player points
//   player2_score  out SCORE_W  right player points
//   point_p1       out 1        one-cycle pulse when player 1 scores
//   point_p2       out 1        one-cycle pulse when player 2 scores
//   game_over      out 1        match decided
//   winner         out 1        0 = player 1, 1 = player 2 (0 unless game_over)
module match_score_controller
    import vga_pkg::*;
#(
    parameter int unsigned SCORE_W    = 4,
    parameter int unsigned WIN_SCORE  = 9,
    parameter int unsigned WIN_BY_TWO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_tick,
    input  logic [10:0]        x_ball,
    input  logic [1:0]         state,
    output logic [SCORE_W-1:0] player1_score,
    output logic [SCORE_W-1:0] player2_score,
    output logic               point_p1,
    output logic               point_p2,
    output logic               game_over,
    output logic               winner
);

    typedef enum logic [1:0] {StWaitReturn, StArmed, StMatchOver} st_e;

    localparam logic [SCORE_W:0] ScoreMax = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0] WinScore = (SCORE_W + 1)'(WIN_SCORE);

    st_e                st_q;
    logic [SCORE_W-1:0] p1_q, p2_q;
    logic               point_p1_q, point_p2_q, game_over_q, winner_q;

    logic goal_left, goal_right, in_field;

    goal_detector u_goal_detector (
        .x_ball     (x_ball),
        .goal_left  (goal_left),
        .goal_right (goal_right),
        .in_field   (in_field)
    );

    // Post-point scores for whichever player scores this tick; left goal has priority.
    logic [SCORE_W-1:0] scorer, opp, scorer_d, opp_d;
    logic [SCORE_W:0]   sum;
    logic               win;

    always_comb begin
        scorer = goal_left ? p2_q : p1_q;
        opp    = goal_left ? p1_q : p2_q;
        sum    = {1'b0, scorer} + (SCORE_W + 1)'(1);
        if ((WIN_BY_TWO != 0) && (sum > ScoreMax)) begin
            // Deuce collapse: drop both by one, then add the point; lead is preserved.
            scorer_d = scorer;
            opp_d    = opp - SCORE_W'(1);
        end else begin
            scorer_d = sum[SCORE_W-1:0];
            opp_d    = opp;
        end
        if (WIN_BY_TWO != 0) begin
            win = ({1'b0, scorer_d} >= WinScore) &&
                  ({1'b0, scorer_d} >= ({1'b0, opp_d} + (SCORE_W + 1)'(2)));
        end else begin
            win = ({1'b0, scorer_d} == WinScore);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state == MENU_START)) begin
            st_q        <= StWaitReturn;
            p1_q        <= '0;
            p2_q        <= '0;
            point_p1_q  <= 1'b0;
            point_p2_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            point_p1_q <= 1'b0;
            point_p2_q <= 1'b0;
            if (timing_tick) begin
                unique case (st_q)
                    StWaitReturn: begin
                        if (in_field) begin
                            st_q <= StArmed;
                        end
                    end
                    StArmed: begin
                        if (goal_left || goal_right) begin
                            if (goal_left) begin
                                p2_q       <= scorer_d;
                                p1_q       <= opp_d;
                                point_p2_q <= 1'b1;
                            end else begin
                                p1_q       <= scorer_d;
                                p2_q       <= opp_d;
                                point_p1_q <= 1'b1;
                            end
                            if (win) begin
                                st_q        <= StMatchOver;
                                game_over_q <= 1'b1;
                                winner_q    <= goal_left;
                            end else begin
                                st_q <= StWaitReturn;
                            end
                        end
                    end
                    StMatchOver: begin
                        st_q <= StMatchOver;
                    end
                    default: begin
                        st_q <= StWaitReturn;
                    end
                endcase
            end
        end
    end

    assign player1_score = p1_q;
    assign player2_score = p2_q;
    assign point_p1      = point_p1_q;
    assign point_p2      = point_p2_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_match_score_controller.sv
// Bench for match_score_controller: default instance (first-to-9) and a win-by-two instance
// (SCORE_W=3, WIN_SCORE=3) share stimulus; each step pushes its expected outputs to a queue
// and pops/compares them one cycle later.
module tb_match_score_controller;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_tick;
    logic [10:0] x_ball;
    logic [1:0]  state;

    logic [3:0] a_p1, a_p2;
    logic       a_pp1, a_pp2, a_go, a_win;
    logic [2:0] b_p1, b_p2;
    logic       b_pp1, b_pp2, b_go, b_win;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    match_score_controller u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .timing_tick   (timing_tick),
        .x_ball        (x_ball),
        .state         (state),
        .player1_score (a_p1),
        .player2_score (a_p2),
        .point_p1      (a_pp1),
        .point_p2      (a_pp2),
        .game_over     (a_go),
        .winner        (a_win)
    );

    match_score_controller #(
        .SCORE_W    (3),
        .WIN_SCORE  (3),
        .WIN_BY_TWO (1)
    ) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .timing_tick   (timing_tick),
        .x_ball        (x_ball),
        .state         (state),
        .player1_score (b_p1),
        .player2_score (b_p2),
        .point_p1      (b_pp1),
        .point_p2      (b_pp2),
        .game_over     (b_go),
        .winner        (b_win)
    );

    typedef struct {
        string      tag;
        bit         sel;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       pp1;
        logic       pp2;
        logic       go;
        logic       win;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input string field, input logic [3:0] obs,
                       input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        logic [3:0] o1, o2;
        logic       opp1, opp2, ogo, owin;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        if (e.sel) begin
            o1 = {1'b0, b_p1}; o2 = {1'b0, b_p2};
            opp1 = b_pp1; opp2 = b_pp2; ogo = b_go; owin = b_win;
        end else begin
            o1 = a_p1; o2 = a_p2;
            opp1 = a_pp1; opp2 = a_pp2; ogo = a_go; owin = a_win;
        end
        chk(e.tag, "player1_score", o1, e.p1);
        chk(e.tag, "player2_score", o2, e.p2);
        chk(e.tag, "point_p1", {3'b0, opp1}, {3'b0, e.pp1});
        chk(e.tag, "point_p2", {3'b0, opp2}, {3'b0, e.pp2});
        chk(e.tag, "game_over", {3'b0, ogo}, {3'b0, e.go});
        chk(e.tag, "winner", {3'b0, owin}, {3'b0, e.win});
    endtask

    // Drive one cycle of inputs, record expected outputs for the next cycle, then compare.
    task automatic step(input bit sel, input logic tk, input logic [10:0] x,
                        input logic [1:0] st, input logic r, input string tag,
                        input logic [3:0] e1, input logic [3:0] e2, input logic epp1,
                        input logic epp2, input logic ego, input logic ewin);
        exp_t e;
        e.tag = tag; e.sel = sel; e.p1 = e1; e.p2 = e2;
        e.pp1 = epp1; e.pp2 = epp2; e.go = ego; e.win = ewin;
        sb.push_back(e);
        timing_tick = tk;
        x_ball      = x;
        state       = st;
        rst         = r;
        @(posedge clk);
        #1;
        compare_front();
    endtask

    int unsigned b_scorer[18] = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 2, 2};
    int unsigned b_e1[18]     = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 7, 7, 6, 5};
    int unsigned b_e2[18]     = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 6, 7, 7, 7};

    initial begin
        rst = 1'b1; timing_tick = 1'b0; x_ball = 11'd0; state = GAME_PLAY;
        @(posedge clk);
        #1;

        // Reset with ball parked in the left goal: no scoring until re-armed.
        step(0, 1, 11'd0, GAME_PLAY, 1, "reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 11'd0, GAME_PLAY, 0, "parked", 0, 0, 0, 0, 0, 0);
        end
        step(0, 1, 11'd512, GAME_PLAY, 0, "arm", 0, 0, 0, 0, 0, 0);
        step(0, 1, 11'd0, GAME_PLAY, 0, "p2_goal", 0, 1, 0, 1, 0, 0);
        step(0, 0, 11'd0, GAME_PLAY, 0, "p2_pulse_end", 0, 1, 0, 0, 0, 0);
        step(0, 1, 11'd0, GAME_PLAY, 0, "p2_no_rescore", 0, 1, 0, 0, 0, 0);

        // Ball held in the right goal: one point per excursion.
        step(0, 1, 11'd512, GAME_PLAY, 0, "arm", 0, 1, 0, 0, 0, 0);
        step(0, 1, 11'd2047, GAME_PLAY, 0, "p1_goal", 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 11'd2047, GAME_PLAY, 0, "p1_held", 1, 1, 0, 0, 0, 0);
        end
        step(0, 1, 11'd512, GAME_PLAY, 0, "arm", 1, 1, 0, 0, 0, 0);
        step(0, 1, 11'd2047, GAME_PLAY, 0, "p1_goal2", 2, 1, 1, 0, 0, 0);

        // Menu restart clears everything.
        step(0, 1, 11'd512, MENU_START, 0, "menu", 0, 0, 0, 0, 0, 0);

        // Tick gating: no evaluation while timing_tick is low.
        step(0, 1, 11'd512, GAME_PLAY, 0, "arm", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 11'd0, GAME_PLAY, 0, "gated", 0, 0, 0, 0, 0, 0);
        end
        step(0, 1, 11'd0, GAME_PLAY, 0, "gated_first_tick", 0, 1, 0, 1, 0, 0);

        // Player 1 runs to 9 and wins.
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 11'd512, GAME_PLAY, 0, "win_arm", 4'(i - 1), 1, 0, 0, 0, 0);
            step(0, 1, 11'd2047, GAME_PLAY, 0, "win_goal", 4'(i), 1, 1, 0, i == 9, 0);
        end

        // Frozen after the match is decided.
        step(0, 1, 11'd512, GAME_PLAY, 0, "frozen_mid", 9, 1, 0, 0, 1, 0);
        step(0, 1, 11'd2047, GAME_PLAY, 0, "frozen_right", 9, 1, 0, 0, 1, 0);
        step(0, 1, 11'd0, GAME_PLAY, 0, "frozen_left", 9, 1, 0, 0, 1, 0);

        // Menu restart from MATCH_OVER; then back in WAIT_RETURN (parked goal ignored).
        step(0, 1, 11'd512, MENU_START, 0, "menu_over", 0, 0, 0, 0, 0, 0);
        step(0, 1, 11'd0, GAME_PLAY, 0, "menu_wait", 0, 0, 0, 0, 0, 0);

        // rst mid-rally, overriding a goal tick in the same cycle.
        step(0, 1, 11'd512, GAME_PLAY, 0, "rally_arm", 0, 0, 0, 0, 0, 0);
        step(0, 1, 11'd2047, GAME_PLAY, 0, "rally_goal", 1, 0, 1, 0, 0, 0);
        step(0, 1, 11'd512, GAME_PLAY, 0, "rally_arm2", 1, 0, 0, 0, 0, 0);
        step(0, 1, 11'd2047, GAME_PLAY, 1, "rally_rst", 0, 0, 0, 0, 0, 0);
        step(0, 1, 11'd2047, GAME_PLAY, 0, "rst_wait", 0, 0, 0, 0, 0, 0);

        // Win-by-two instance: deuce collapse and final two-point lead.
        step(1, 1, 11'd512, GAME_PLAY, 1, "b_reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            step(1, 1, 11'd512, GAME_PLAY, 0, "b_arm",
                 (i == 0) ? 4'd0 : 4'(b_e1[i-1]), (i == 0) ? 4'd0 : 4'(b_e2[i-1]),
                 0, 0, 0, 0);
            step(1, 1, (b_scorer[i] == 1) ? 11'd2047 : 11'd0, GAME_PLAY, 0, "b_goal",
                 4'(b_e1[i]), 4'(b_e2[i]), b_scorer[i] == 1, b_scorer[i] == 2,
                 i == 17, i == 17);
        end
        step(1, 1, 11'd512, GAME_PLAY, 0, "b_frozen", 5, 7, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_score_controller.md
# match_score_controller

Parametrised point and match tracker for pong. It watches the ball x position on each `timing_tick` and scores one point per goal, with re-arming so each goal counts only once. It detects the match winner, with an optional win-by-two mode, and freezes scoring until the menu restarts the game. It sits between the ball/paddle logic and the score display and game-state control, and drives score digits, one-cycle point pulses and `game_over`/`winner`.

## Interface
Parameters:
- `SCORE_W`, 4: width of each score output.
- `WIN_SCORE`, 9: points needed to win; 1 ≤ `WIN_SCORE` ≤ 2^`SCORE_W`−2.
- `WIN_BY_TWO`, 0: 1 means a win also needs a lead of ≥2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `timing_tick`  in  1  frame-rate enable; detection is evaluated only when this is high.
- `x_ball`  in  11  ball left edge, in pixels.
- `state`  in  2  game state; `MENU_START` acts as a match reset.
- `player1_score`  out  `SCORE_W`  left player points.
- `player2_score`  out  `SCORE_W`  right player points.
- `point_p1`  out  1  one-cycle pulse when player 1 scores.
- `point_p2`  out  1  one-cycle pulse when player 2 scores.
- `game_over`  out  1  high while the match is decided.
- `winner`  out  1  0 = player 1, 1 = player 2; valid only while `game_over` is high, 0 otherwise.

## Operation
- Goal conditions, evaluated only when `timing_tick` is high:
  - left goal: `x_ball < X_PAD_LEFT` → player 2 scores;
  - right goal: `x_ball + BALL_SIZE > X_PAD_RIGHT + PAD_WIDTH` → player 1 scores.
  - Left is checked first and has priority.
  - Comparisons are 12-bit unsigned, so the sum cannot overflow.
- In-field: neither goal condition holds.
- FSM states:
  - WAIT_RETURN: not armed. Tick with ball in-field → ARMED. Goal conditions are ignored.
  - ARMED: tick with a goal condition → increment the scorer's score, pulse the matching `point_p*`, then evaluate the win. Win → MATCH_OVER, else → WAIT_RETURN.
  - MATCH_OVER: `game_over`=1 and `winner` held. All ticks are ignored. Exit only via `rst` or `MENU_START`.
- Win test uses the post-increment scores:
  - `WIN_BY_TWO`=0: scorer's score == `WIN_SCORE`.
  - `WIN_BY_TWO`=1: scorer's score ≥ `WIN_SCORE` and scorer minus opponent ≥ 2.
- Deuce collapse (`WIN_BY_TWO`=1 only): if the increment would exceed 2^`SCORE_W`−1 without a win, decrement both scores by 1 instead, then add the point. The difference is preserved and nothing wraps.
- Scores never wrap. Saturation is implied by the win/collapse rules.
- `rst`, or `state == MENU_START` in any cycle, sets:
  - both scores to 0,
  - pulses, `game_over` and `winner` to 0,
  - FSM to WAIT_RETURN, so a ball parked in a goal at start never scores.
- `rst` and `MENU_START` have equal priority, and both override a tick in the same cycle.

## Timing
- All outputs are registered; reset value of every output is 0.
- Goal tick at cycle N:
  - new score visible at N+1;
  - `point_p*` high during N+1 only;
  - `game_over` rises at N+1 if the point wins.
- Re-arm tick at cycle M: ARMED from M+1. The earliest next goal is the following tick.
- At most one point per tick, and at most one point per out-of-field excursion.
- `timing_tick` held high for consecutive cycles is legal; each cycle is evaluated.

## Structure
- vga_pkg holds the shared constants: `X_PAD_LEFT`, `X_PAD_RIGHT`, `PAD_WIDTH`, `BALL_SIZE`, `MENU_START`.
- The FSM state enum is local to the module.
- One sub-module is natural: `goal_detector`.
  - Combinational from `x_ball`.
  - Outputs `goal_left`, `goal_right`, `in_field`.
  - Reused later by the ball-respawn logic.
- Target size: 150–250 lines.

## Test plan
- **Reset re-arm:** defaults; reset with `x_ball`=0, ticks → scores stay 0/0. Move `x_ball`=512 (mid-field), tick, then `x_ball`=0, tick → `player2_score`=1 and `point_p2` high for exactly one cycle.
- **Single count per excursion:** ball held at `x_ball`=2047 for 10 ticks → `player1_score`=1, one `point_p1` pulse. Return to 512, tick, back to 2047 → `player1_score`=2.
- **Win and freeze:** alternate 512/2047 nine times → `player1_score`=9 and `game_over`=1, `winner`=0 one cycle after the 9th goal tick. Further goals leave 9/0.
- **Menu restart:** in MATCH_OVER assert `state`=`MENU_START` for one cycle → all outputs 0 next cycle, FSM in WAIT_RETURN. Same check with `rst` asserted mid-rally.
- **Win by two:** `WIN_BY_TWO`=1, `WIN_SCORE`=3, `SCORE_W`=3, drive 3–3 → no `game_over`. Continue alternating points up to 7 → scores collapse (7–6 then scorer at 7 → 6–7 style) and never wrap. Two consecutive player 2 points → `winner`=1.
- **Tick gating:** `x_ball`=0 while ARMED with `timing_tick`=0 for 100 cycles → no score change. First tick → point on the next cycle.
